// File: rtl/pc_ctrl_pkg.sv
// Shared types and helpers for the fetch-PC redirect controller.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    FLUSH,
    DRAIN,
    HALTED
  } pc_state_t;

  localparam int PC_STEP = 4;

  // A target is illegal if it is not word aligned or lies beyond instruction memory.
  function automatic logic is_illegal_target(input logic [31:0] br_pc, input int pc_w);
    return (br_pc[1:0] != 2'b00) || ((br_pc >> pc_w) != 32'd0);
  endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down counter shared by the flush and drain sequences.
// Load wins over decrement; zero is combinational from the stored count.
module cycle_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: redirects on taken branches, flushes younger slots, drains on halt, traps bad targets.
// Redirect accepted at edge N gives PC=target and Flush=1 in cycle N+1; redirect overrides Stall.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              PC_W         = 9,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            flag_halt,
  output logic [PC_W-1:0] PC,
  output logic            FetchValid,
  output logic            Flush,
  output logic            Halted,
  output logic            BrErr
);

  localparam int MAX_CYC = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  pc_state_t       r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_flush;
  logic            r_halted;
  logic            r_brerr;

  logic            w_run;
  logic            w_illegal;
  logic            w_acc_halt;
  logic            w_acc_err;
  logic            w_acc_redir;
  logic            w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic            w_cnt_dec;
  logic            w_cnt_zero;
  logic [PC_W-1:0] w_pc_next_seq;

  assign w_run       = (r_state == RUN);
  assign w_illegal   = is_illegal_target(BrPC, PC_W);
  // Halt outranks any redirect issued in the same cycle.
  assign w_acc_halt  = w_run && flag_halt;
  assign w_acc_err   = w_run && !flag_halt && PcSel && w_illegal;
  assign w_acc_redir = w_run && !flag_halt && PcSel && !w_illegal;

  assign w_cnt_load  = w_acc_halt || w_acc_err || w_acc_redir;
  assign w_cnt_val   = w_acc_redir ? CNT_W'(FLUSH_CYCLES - 1) : CNT_W'(DRAIN_CYCLES - 1);
  assign w_cnt_dec   = ((r_state == FLUSH) || (r_state == DRAIN)) && !w_cnt_zero;

  assign w_pc_next_seq = r_pc + PC_W'(PC_STEP);

  cycle_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .dec      (w_cnt_dec),
    .zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= BOOT;
      r_pc     <= RESET_PC;
      r_flush  <= 1'b0;
      r_halted <= 1'b0;
      r_brerr  <= 1'b0;
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (w_acc_halt) begin
            r_state <= DRAIN;
          end else if (w_acc_err) begin
            r_brerr <= 1'b1;
            r_state <= DRAIN;
          end else if (w_acc_redir) begin
            r_pc    <= BrPC[PC_W-1:0];
            r_flush <= 1'b1;
            r_state <= FLUSH;
          end else if (!Stall) begin
            r_pc <= w_pc_next_seq;
          end
        end
        FLUSH: begin
          if (!Stall) begin
            r_pc <= w_pc_next_seq;
          end
          if (w_cnt_zero) begin
            r_flush <= 1'b0;
            r_state <= RUN;
          end
        end
        DRAIN: begin
          if (w_cnt_zero) begin
            r_halted <= 1'b1;
            r_state  <= HALTED;
          end
        end
        HALTED: r_state <= HALTED;
        default: r_state <= BOOT;
      endcase
    end
  end

  assign PC         = r_pc;
  assign FetchValid = ((r_state == RUN) || (r_state == FLUSH)) && !Stall;
  assign Flush      = r_flush;
  assign Halted     = r_halted;
  assign BrErr      = r_brerr;

endmodule
